// File: rtl/btn_debounce.sv
// Per-channel synchroniser and debouncer for raw push-buttons.
// Each channel has a two-flop sync, a stability counter, a registered level and press/release pulses.
module btn_debounce #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [CNT_W-1:0] cnt [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // Count clears on the flip, so it never runs past CNT_LAST.
                    btn_level[i]   <= s2[i];
                    btn_press[i]   <= s2[i];
                    btn_release[i] <= ~s2[i];
                    cnt[i]         <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4: level flips on the 6th edge of stable input.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int passes = 0;
    int total  = 0;

    btn_debounce #(.N(4), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                       input logic [3:0] rel);
        cmp({tag, ".level"}, btn_level, lvl);
        cmp({tag, ".press"}, btn_press, prs);
        cmp({tag, ".release"}, btn_release, rel);
    endtask

    initial begin
        // Reset held with all buttons down, then full debounce after release.
        rst     = 1'b1;
        btn_raw = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold", 4'b0000, 4'b0000, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        chk("post_rst_flip", 4'b1111, 4'b1111, 4'b0000);
        tick();
        chk("post_rst_after", 4'b1111, 4'b0000, 4'b0000);

        // Clean slate with all buttons released.
        rst     = 1'b1;
        btn_raw = 4'b0000;
        tick();
        tick();
        chk("rst_clear", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        tick();
        tick();

        // Channel 0 press.
        btn_raw = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ch0_press_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        chk("ch0_press_flip", 4'b0001, 4'b0001, 4'b0000);
        tick();
        chk("ch0_press_after", 4'b0001, 4'b0000, 4'b0000);

        // Channel 1 high for only 3 cycles: rejected.
        btn_raw = 4'b0011;
        tick();
        tick();
        tick();
        btn_raw = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ch1_glitch", 4'b0001, 4'b0000, 4'b0000);
        end

        // Channel 2 bounce 1,0,1,1,0 then held 1.
        btn_raw = 4'b0101; tick(); chk("ch2_bounce", 4'b0001, 4'b0000, 4'b0000);
        btn_raw = 4'b0001; tick(); chk("ch2_bounce", 4'b0001, 4'b0000, 4'b0000);
        btn_raw = 4'b0101; tick(); chk("ch2_bounce", 4'b0001, 4'b0000, 4'b0000);
        btn_raw = 4'b0101; tick(); chk("ch2_bounce", 4'b0001, 4'b0000, 4'b0000);
        btn_raw = 4'b0001; tick(); chk("ch2_bounce", 4'b0001, 4'b0000, 4'b0000);
        btn_raw = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ch2_settle_wait", 4'b0001, 4'b0000, 4'b0000);
        end
        tick();
        chk("ch2_settle_flip", 4'b0101, 4'b0100, 4'b0000);
        tick();
        chk("ch2_settle_after", 4'b0101, 4'b0000, 4'b0000);

        // Channel 0 release.
        btn_raw = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ch0_rel_wait", 4'b0101, 4'b0000, 4'b0000);
        end
        tick();
        chk("ch0_rel_flip", 4'b0100, 4'b0000, 4'b0001);
        tick();
        chk("ch0_rel_after", 4'b0100, 4'b0000, 4'b0000);

        // Channel 3 partial count, then reset discards it; ch2 also re-debounces.
        btn_raw = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ch3_partial", 4'b0100, 4'b0000, 4'b0000);
        end
        rst = 1'b1;
        tick();
        chk("ch3_rst", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ch3_fresh_wait", 4'b0000, 4'b0000, 4'b0000);
        end
        tick();
        chk("ch3_fresh_flip", 4'b1100, 4'b1100, 4'b0000);
        tick();
        chk("ch3_fresh_after", 4'b1100, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
